// File: rtl/preg_freelist_if.sv
// rtl/preg_freelist_if.sv - rename/commit side signals of the physical-register free list
// master = decode/commit side that drives requests, slave = the free list itself.
interface preg_freelist_if #(
    parameter int PW = 6
);
    logic          clear;
    logic [1:0]    alloc_req;
    logic          alloc_en;
    logic          alloc_ok;
    logic          stalled;
    logic [PW-1:0] preg1;
    logic [PW-1:0] preg2;
    logic [1:0]    free_valid;
    logic [PW-1:0] free_preg1;
    logic [PW-1:0] free_preg2;
    logic [1:0]    retire_cnt;
    logic [PW:0]   num_free;

    modport master (
        output clear, alloc_req, alloc_en, free_valid, free_preg1, free_preg2, retire_cnt,
        input  alloc_ok, stalled, preg1, preg2, num_free
    );

    modport slave (
        input  clear, alloc_req, alloc_en, free_valid, free_preg1, free_preg2, retire_cnt,
        output alloc_ok, stalled, preg1, preg2, num_free
    );
endinterface

// File: rtl/preg_freelist.sv
// rtl/preg_freelist.sv - two-wide physical-register free list with flush rollback
// Circular array between spec_head (next to hand out) and tail (next free slot to fill).
module preg_freelist #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input  logic             clk,
    input  logic             reset,
    preg_freelist_if.slave   fl
);

    logic [PW-1:0] fifo [NUM_PREGS];
    logic [PW:0]   spec_head;
    logic [PW:0]   commit_head;
    logic [PW:0]   tail;

    logic [PW:0]   alloc_n;
    logic [PW:0]   free_n;
    logic [PW:0]   retire_n;
    logic [PW:0]   spec_next;
    logic [PW:0]   tail_next;
    logic          alloc_go;

    always_comb begin
        alloc_n   = (PW+1)'(fl.alloc_req[0]) + (PW+1)'(fl.alloc_req[1]);
        free_n    = (PW+1)'(fl.free_valid[0]) + (PW+1)'(fl.free_valid[1]);
        retire_n  = (PW+1)'(fl.retire_cnt);
        spec_next = spec_head + 1'b1;
        tail_next = tail + 1'b1;
    end

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign fl.num_free = tail - spec_head;
    assign fl.alloc_ok = (fl.num_free >= alloc_n);
    assign fl.stalled  = (fl.alloc_req != 2'b00) && !fl.alloc_ok;
    assign fl.preg1    = fifo[spec_head[PW-1:0]];
    assign fl.preg2    = fl.alloc_req[0] ? fifo[spec_next[PW-1:0]] : fifo[spec_head[PW-1:0]];

    assign alloc_go = fl.alloc_en && fl.alloc_ok && !fl.clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                fifo[i] <= PW'(NUM_AREGS + i);
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= (PW+1)'(NUM_PREGS - NUM_AREGS);
        end else begin
            commit_head <= commit_head + retire_n;

            // Rollback targets the commit point including this cycle's retirements.
            if (fl.clear) begin
                spec_head <= commit_head + retire_n;
            end else if (alloc_go) begin
                spec_head <= spec_head + alloc_n;
            end

            case (fl.free_valid)
                2'b01: fifo[tail[PW-1:0]] <= fl.free_preg1;
                2'b10: fifo[tail[PW-1:0]] <= fl.free_preg2;
                2'b11: begin
                    fifo[tail[PW-1:0]]      <= fl.free_preg1;
                    fifo[tail_next[PW-1:0]] <= fl.free_preg2;
                end
                default: ;
            endcase
            tail <= tail + free_n;
        end
    end

endmodule

// File: tb/tb_preg_freelist.sv
// tb/tb_preg_freelist.sv - queue-model bench for preg_freelist
// Model: free_q holds handable pregs in order, spec_q holds uncommitted allocations.
module tb_preg_freelist;
    localparam int NP = 64;
    localparam int NA = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    preg_freelist_if #(.PW(6)) fl ();
    preg_freelist dut (.clk(clk), .reset(reset), .fl(fl));

    int checks   = 0;
    int failures = 0;
    int free_q[$];
    int spec_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pop2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = 0; i < NP - NA; i++) free_q.push_back(NA + i);
    endtask

    task automatic set_in(input logic [1:0] req, input logic en, input logic clr,
                          input logic [1:0] fv, input int p1, input int p2, input logic [1:0] rt);
        fl.alloc_req  = req;
        fl.alloc_en   = en;
        fl.clear      = clr;
        fl.free_valid = fv;
        fl.free_preg1 = 6'(p1);
        fl.free_preg2 = 6'(p2);
        fl.retire_cnt = rt;
    endtask

    // Single comparison point: outputs versus the queue model, every cycle.
    task automatic sample();
        int  n;
        bit  okx;
        @(negedge clk);
        n   = pop2(fl.alloc_req);
        okx = (n <= free_q.size());
        chk("alloc_ok", int'(fl.alloc_ok), int'(okx));
        chk("stalled", int'(fl.stalled), int'((fl.alloc_req != 2'b00) && !okx));
        chk("num_free", int'(fl.num_free), free_q.size());
        if (free_q.size() >= 1) chk("preg1", int'(fl.preg1), free_q[0]);
        if (fl.alloc_req[1] && okx)
            chk("preg2", int'(fl.preg2), fl.alloc_req[0] ? free_q[1] : free_q[0]);
    endtask

    task automatic advance();
        int n;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int r = 0; r < int'(fl.retire_cnt); r++)
                if (spec_q.size() > 0) void'(spec_q.pop_front());
            if (fl.clear) begin
                for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
                spec_q.delete();
            end else begin
                n = pop2(fl.alloc_req);
                if (fl.alloc_en && n <= free_q.size())
                    for (int k = 0; k < n; k++) spec_q.push_back(free_q.pop_front());
            end
            if (fl.free_valid[0]) free_q.push_back(int'(fl.free_preg1));
            if (fl.free_valid[1]) free_q.push_back(int'(fl.free_preg2));
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        advance();
        reset = 1'b0;
    endtask

    initial begin
        int room, rt, mode, steady_nf;
        logic [1:0] req, fv;

        do_reset();

        // First 2-wide allocation out of reset.
        set_in(2'b11, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_first_preg1", int'(fl.preg1), 32);
        chk("lit_first_preg2", int'(fl.preg2), 33);
        chk("lit_first_ok", int'(fl.alloc_ok), 1);
        advance();
        set_in(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_after_nf", int'(fl.num_free), 30);
        chk("lit_after_preg1", int'(fl.preg1), 34);
        advance();

        // Drain to one entry, then exercise the stall boundary.
        for (int i = 0; i < 14; i++) begin
            set_in(2'b11, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
            sample();
            advance();
        end
        set_in(2'b01, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        advance();
        set_in(2'b11, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_stall_ok", int'(fl.alloc_ok), 0);
        chk("lit_stall_stalled", int'(fl.stalled), 1);
        advance();
        set_in(2'b10, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_held_nf", int'(fl.num_free), 1);
        chk("lit_slot1_ok", int'(fl.alloc_ok), 1);
        chk("lit_slot1_preg2", int'(fl.preg2), 63);
        advance();

        // Empty list: allocation refused while the same-cycle frees land.
        set_in(2'b01, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        advance();
        set_in(2'b01, 1'b1, 1'b0, 2'b11, 5, 7, 2'b00);
        sample();
        chk("lit_empty_ok", int'(fl.alloc_ok), 0);
        advance();
        set_in(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_refill_nf", int'(fl.num_free), 2);
        chk("lit_refill_preg1", int'(fl.preg1), 5);
        chk("lit_refill_preg2", int'(fl.preg2), 7);
        advance();

        // Rollback: 6 allocated, 2 retired, clear with 1 more retiring.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b11, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
            sample();
            advance();
        end
        set_in(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b10);
        sample();
        advance();
        set_in(2'b11, 1'b1, 1'b1, 2'b00, 0, 0, 2'b01);
        sample();
        advance();
        set_in(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_clear_nf", int'(fl.num_free), 29);
        chk("lit_clear_preg1", int'(fl.preg1), 35);
        advance();

        // Steady 2-alloc/2-free with retirement: count constant, order preserved.
        do_reset();
        steady_nf = 32;
        for (int i = 0; i < 200; i++) begin
            rt = (spec_q.size() < 2) ? spec_q.size() : 2;
            set_in(2'b11, 1'b1, 1'b0, 2'b11, $urandom_range(0, 63), $urandom_range(0, 63), 2'(rt));
            sample();
            chk("steady_nf", int'(fl.num_free), steady_nf);
            advance();
        end

        // Reset mid-operation with frees in flight.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_in(2'b11, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
            sample();
            advance();
        end
        reset = 1'b1;
        set_in(2'b11, 1'b1, 1'b0, 2'b11, 9, 11, 2'b01);
        sample();
        chk("lit_prereset_nf", int'(fl.num_free), 10);
        advance();
        reset = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        sample();
        chk("lit_postreset_nf", int'(fl.num_free), 32);
        chk("lit_postreset_preg1", int'(fl.preg1), 32);
        advance();

        // Randomized phase with biased modes to visit empty, full and wrap cases.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                continue;
            end
            mode = (c / 150) % 3;
            req  = 2'($urandom_range(0, 3));
            rt   = $urandom_range(0, (spec_q.size() < 2) ? spec_q.size() : 2);
            if (mode == 1 && spec_q.size() >= 2) rt = 2;
            case (mode)
                0:       fv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                1:       fv = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                default: fv = 2'($urandom_range(0, 3));
            endcase
            room = NP - (free_q.size() + spec_q.size() - rt);
            if (room <= 0) fv = 2'b00;
            else if (room == 1 && fv == 2'b11) fv = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            set_in(req, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), fv,
                   $urandom_range(0, 63), $urandom_range(0, 63), 2'(rt));
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
